// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX boundary register for the ALU.
// Decodes the ALU class plus opcode/funct into a 3-bit ALUOP and picks the
// second operand (register or extended immediate). All EX outputs, including
// the saturating bubble counter, come straight from flops.
module alu_issue_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [1:0]       id_aluclass,
  input  logic [5:0]       id_opcode,
  input  logic [5:0]       id_funct,
  input  logic [WIDTH-1:0] id_rs_data,
  input  logic [WIDTH-1:0] id_rt_data,
  input  logic [15:0]      id_imm,
  input  logic             id_alusrc,
  input  logic [4:0]       id_rd,
  output logic             ex_valid,
  output logic [WIDTH-1:0] ex_in1,
  output logic [WIDTH-1:0] ex_in2,
  output logic [2:0]       ex_aluop,
  output logic [4:0]       ex_rd,
  output logic             ex_illegal,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic             valid_q,   valid_d;
  logic [WIDTH-1:0] in1_q,     in1_d;
  logic [WIDTH-1:0] in2_q,     in2_d;
  logic [2:0]       aluop_q,   aluop_d;
  logic [4:0]       rd_q,      rd_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  logic [2:0]       aluop_dec;
  logic             legal;
  logic             zext;
  logic [WIDTH-1:0] imm_ext;
  logic             cnt_inc;

  // Decode class/opcode/funct to ALUOP; legality ignores id_alusrc.
  always_comb begin
    aluop_dec = OP_ADD;
    legal     = 1'b1;
    zext      = 1'b0;
    case (id_aluclass)
      2'b00: aluop_dec = OP_ADD;
      2'b01: aluop_dec = OP_SUB;
      2'b10: begin
        case (id_funct)
          6'h20:   aluop_dec = OP_ADD;
          6'h22:   aluop_dec = OP_SUB;
          6'h24:   aluop_dec = OP_AND;
          6'h25:   aluop_dec = OP_OR;
          6'h2A:   aluop_dec = OP_SLT;
          default: legal     = 1'b0;
        endcase
      end
      default: begin
        case (id_opcode)
          6'h08:   aluop_dec = OP_ADD;
          6'h0A:   aluop_dec = OP_SLT;
          6'h0C: begin
            aluop_dec = OP_AND;
            zext      = 1'b1;
          end
          6'h0D: begin
            aluop_dec = OP_OR;
            zext      = 1'b1;
          end
          default: legal = 1'b0;
        endcase
      end
    endcase
    imm_ext = zext ? {{(WIDTH-16){1'b0}}, id_imm}
                   : {{(WIDTH-16){id_imm[15]}}, id_imm};
  end

  // Next EX contents: flush beats stall beats load; idle slots are not counted.
  always_comb begin
    valid_d   = valid_q;
    in1_d     = in1_q;
    in2_d     = in2_q;
    aluop_d   = aluop_q;
    rd_d      = rd_q;
    illegal_d = illegal_q;
    cnt_inc   = 1'b0;
    if (flush) begin
      valid_d   = 1'b0;
      in1_d     = '0;
      in2_d     = '0;
      aluop_d   = OP_ADD;
      rd_d      = '0;
      illegal_d = 1'b0;
      cnt_inc   = 1'b1;
    end else if (!stall) begin
      if (id_valid && legal) begin
        valid_d   = 1'b1;
        in1_d     = id_rs_data;
        in2_d     = id_alusrc ? imm_ext : id_rt_data;
        aluop_d   = aluop_dec;
        rd_d      = id_rd;
        illegal_d = 1'b0;
      end else begin
        valid_d   = 1'b0;
        in1_d     = '0;
        in2_d     = '0;
        aluop_d   = OP_ADD;
        rd_d      = '0;
        illegal_d = id_valid;
        cnt_inc   = id_valid;
      end
    end
    if (cnt_inc && (bubble_cnt_q != {CNT_W{1'b1}}))
      bubble_cnt_d = bubble_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    else
      bubble_cnt_d = bubble_cnt_q;
  end

  // EX stage registers; reset loads the bubble image.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      in1_q        <= '0;
      in2_q        <= '0;
      aluop_q      <= OP_ADD;
      rd_q         <= '0;
      illegal_q    <= 1'b0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      in1_q        <= in1_d;
      in2_q        <= in2_d;
      aluop_q      <= aluop_d;
      rd_q         <= rd_d;
      illegal_q    <= illegal_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ex_valid   = valid_q;
  assign ex_in1     = in1_q;
  assign ex_in2     = in2_q;
  assign ex_aluop   = aluop_q;
  assign ex_rd      = rd_q;
  assign ex_illegal = illegal_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed steps then random traffic, checked
// against a behavioural model of the EX contents. A second instance with a
// 2-bit counter exercises saturation.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, id_valid, id_alusrc;
  logic [1:0]  id_aluclass;
  logic [5:0]  id_opcode, id_funct;
  logic [31:0] id_rs_data, id_rt_data;
  logic [15:0] id_imm;
  logic [4:0]  id_rd;

  logic        ex_valid, ex_illegal, ex_valid2, ex_illegal2;
  logic [31:0] ex_in1, ex_in2, ex_in1_2, ex_in2_2;
  logic [2:0]  ex_aluop, ex_aluop2;
  logic [4:0]  ex_rd, ex_rd2;
  logic [7:0]  bubble_cnt;
  logic [1:0]  bubble_cnt2;

  int vectors = 0;
  int miscompares = 0;

  // behavioural model state
  bit          m_valid, m_ill;
  logic [31:0] m_in1, m_in2;
  logic [2:0]  m_aluop;
  logic [4:0]  m_rd;
  int          m_cnt, m_cnt2;

  always #5 clk = ~clk;

  alu_issue_stage #(.WIDTH(32), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_aluclass(id_aluclass), .id_opcode(id_opcode), .id_funct(id_funct),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_alusrc(id_alusrc), .id_rd(id_rd), .ex_valid(ex_valid), .ex_in1(ex_in1),
    .ex_in2(ex_in2), .ex_aluop(ex_aluop), .ex_rd(ex_rd), .ex_illegal(ex_illegal),
    .bubble_cnt(bubble_cnt));

  alu_issue_stage #(.WIDTH(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_aluclass(id_aluclass), .id_opcode(id_opcode), .id_funct(id_funct),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_alusrc(id_alusrc), .id_rd(id_rd), .ex_valid(ex_valid2), .ex_in1(ex_in1_2),
    .ex_in2(ex_in2_2), .ex_aluop(ex_aluop2), .ex_rd(ex_rd2), .ex_illegal(ex_illegal2),
    .bubble_cnt(bubble_cnt2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Instruction semantics: returns ALUOP name code, legality and extension kind.
  task automatic decode(input int cls, input int op, input int fn,
                        output bit ok, output logic [2:0] aop, output bit zx);
    ok = 1; zx = 0; aop = 3'b010;
    if (cls == 0) aop = 3'b010;
    else if (cls == 1) aop = 3'b110;
    else if (cls == 2) begin
      if      (fn == 'h20) aop = 3'b010;
      else if (fn == 'h22) aop = 3'b110;
      else if (fn == 'h24) aop = 3'b000;
      else if (fn == 'h25) aop = 3'b001;
      else if (fn == 'h2A) aop = 3'b111;
      else ok = 0;
    end else begin
      if      (op == 'h08) aop = 3'b010;
      else if (op == 'h0A) aop = 3'b111;
      else if (op == 'h0C) begin aop = 3'b000; zx = 1; end
      else if (op == 'h0D) begin aop = 3'b001; zx = 1; end
      else ok = 0;
    end
  endtask

  task automatic model_bubble();
    m_valid = 0; m_in1 = 0; m_in2 = 0; m_aluop = 3'b010; m_rd = 0;
  endtask

  task automatic model_reset();
    model_bubble();
    m_ill = 0; m_cnt = 0; m_cnt2 = 0;
  endtask

  task automatic model_count();
    if (m_cnt < 255) m_cnt++;
    if (m_cnt2 < 3) m_cnt2++;
  endtask

  // Advance the model by one clock edge using the current ID inputs.
  task automatic model_edge();
    bit ok, zx;
    logic [2:0] aop;
    logic [31:0] ext;
    decode(int'(id_aluclass), int'(id_opcode), int'(id_funct), ok, aop, zx);
    if (zx) ext = 32'(id_imm);
    else    ext = (id_imm >= 16'h8000) ? 32'(id_imm) + 32'hFFFF_0000 : 32'(id_imm);
    if (flush) begin
      model_bubble(); m_ill = 0; model_count();
    end else if (stall) begin
      // everything holds
    end else if (!id_valid) begin
      model_bubble(); m_ill = 0;
    end else if (!ok) begin
      model_bubble(); m_ill = 1; model_count();
    end else begin
      m_valid = 1; m_in1 = id_rs_data; m_in2 = id_alusrc ? ext : id_rt_data;
      m_aluop = aop; m_rd = id_rd; m_ill = 0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"},   32'(ex_valid),    32'(m_valid));
    check({tag, ".in1"},     ex_in1,           m_in1);
    check({tag, ".in2"},     ex_in2,           m_in2);
    check({tag, ".aluop"},   32'(ex_aluop),    32'(m_aluop));
    check({tag, ".rd"},      32'(ex_rd),       32'(m_rd));
    check({tag, ".illegal"}, 32'(ex_illegal),  32'(m_ill));
    check({tag, ".cnt"},     32'(bubble_cnt),  32'(m_cnt));
    check({tag, ".cnt2"},    32'(bubble_cnt2), 32'(m_cnt2));
    check({tag, ".valid2"},  32'(ex_valid2),   32'(m_valid));
    check({tag, ".in2_2"},   ex_in2_2,         m_in2);
  endtask

  // Update model, clock once, then sample 1 time unit after the edge.
  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic set_in(input bit v, input int cls, input int op, input int fn,
                        input logic [31:0] rs, input logic [31:0] rt,
                        input logic [15:0] imm, input bit src, input logic [4:0] rd);
    id_valid = v; id_aluclass = 2'(cls); id_opcode = 6'(op); id_funct = 6'(fn);
    id_rs_data = rs; id_rt_data = rt; id_imm = imm; id_alusrc = src; id_rd = rd;
  endtask

  task automatic rand_in();
    int cls;
    cls = int'($urandom_range(0, 3));
    set_in($urandom_range(0, 7) != 0, cls, 0, 0, $urandom, $urandom,
           16'($urandom), 1'($urandom), 5'($urandom));
    if ($urandom_range(0, 3) == 0) begin
      id_opcode = 6'($urandom); id_funct = 6'($urandom);
    end else begin
      case ($urandom_range(0, 3))
        0: id_opcode = 6'h08; 1: id_opcode = 6'h0A; 2: id_opcode = 6'h0C; default: id_opcode = 6'h0D;
      endcase
      case ($urandom_range(0, 4))
        0: id_funct = 6'h20; 1: id_funct = 6'h22; 2: id_funct = 6'h24;
        3: id_funct = 6'h25; default: id_funct = 6'h2A;
      endcase
    end
  endtask

  initial begin
    rst = 1'b1; stall = 0; flush = 0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #3;
    check_all("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // R-type sub with equal operands: Zero would be set in the ALU
    set_in(1, 2, 0, 'h22, 32'd5, 32'd5, 16'h0, 0, 5'd3);
    step("rtype_sub");
    check("rtype_sub.aluop_const", 32'(ex_aluop), 32'b110);
    check("rtype_sub.zero", ex_in1 - ex_in2, 32'd0);

    // ori zero-extends
    set_in(1, 3, 'h0D, 0, 32'h1234, 32'hDEAD, 16'hFFFF, 1, 5'd4);
    step("ori");
    check("ori.in2_const", ex_in2, 32'h0000_FFFF);

    // addi sign-extends
    set_in(1, 3, 'h08, 0, 32'h10, 32'h0, 16'hFFFB, 1, 5'd5);
    step("addi");
    check("addi.in2_const", ex_in2, 32'hFFFF_FFFB);

    // load add, then stall 3 cycles with changing inputs
    set_in(1, 0, 0, 0, 32'hA, 32'hB, 16'h0, 0, 5'd7);
    step("add");
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      rand_in();
      step("stall");
      check("stall.in1_const", ex_in1, 32'hA);
    end

    // stall and flush together: flush wins
    flush = 1;
    step("stall_flush");
    stall = 0; flush = 0;

    // illegal funct then two idle slots
    set_in(1, 2, 0, 'h3F, 32'h1, 32'h2, 16'h0, 0, 5'd9);
    step("illegal");
    check("illegal.pulse_const", 32'(ex_illegal), 32'd1);
    set_in(0, 2, 0, 'h3F, 32'h1, 32'h2, 16'h0, 0, 5'd9);
    step("idle1");
    step("idle2");

    // saturation of the 2-bit instance
    flush = 1;
    for (int i = 0; i < 5; i++) step("sat_flush");
    check("sat.cnt2_const", 32'(bubble_cnt2), 32'd3);
    flush = 0;

    // asynchronous reset mid-cycle while stalled with a valid instruction
    set_in(1, 0, 0, 0, 32'h55, 32'h66, 16'h0, 0, 5'd1);
    step("pre_rst");
    stall = 1;
    step("pre_rst_stall");
    #2; rst = 1'b1; model_reset();
    #1; check_all("async_rst");
    #1; rst = 1'b0; stall = 0;

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rand_in();
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
